vga_sync_receiver: RTL and testbench

VGA_SYNC_RECEIVER -- requirements
Module: vga_sync_receiver

---
 rtl/vga_sync_receiver.sv | 194 +++++++++++++++++++
 tb/tb_vga_sync_receiver.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_sync_receiver.sv
// vga_sync_receiver: recovers pixel/line position from active-low VGA syncs.
//
// Samples hs/vs once per pixel strobe (pix_ce) and free-runs column/line
// counters that are re-aligned on every sync fall. A four-state acquisition
// FSM (SEARCH -> H_ALIGN -> V_ALIGN -> LOCKED) verifies that sync edges keep
// landing where the programmed timing says they should. Any misplaced edge
// pulses hs_err/vs_err and drops back to SEARCH.
//
// Ports:
//   Clk, Reset       clock, asynchronous active-high reset
//   pix_ce           pixel strobe; nothing moves on Clk edges without it
//   hs, vs           active-low syncs from the transmitter
//   RecvX, RecvY     recovered column / line (10 bits each)
//   locked           timing verified (state LOCKED)
//   active           locked and inside the visible window
//   frame_start      one-Clk pulse when a locked frame wraps to (0,0)
//   hs_err, vs_err   one-Clk pulses on a misplaced sync edge
//   frame_count      locked-frame counter (8 bits)
//
// Configuration macro: VGA_RX_FRAME_COUNT_EN. When defined, frame_count
// counts frame_start pulses and clears when lock is lost; otherwise it is
// tied to zero and has no register.

module vga_sync_receiver #(
  parameter int unsigned H_TOTAL      = 800,
  parameter int unsigned H_ACTIVE     = 640,
  parameter int unsigned H_SYNC_START = 656,
  parameter int unsigned H_SYNC_WIDTH = 96,
  parameter int unsigned V_TOTAL      = 525,
  parameter int unsigned V_ACTIVE     = 480,
  parameter int unsigned V_SYNC_START = 490
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       pix_ce,
  input  logic       hs,
  input  logic       vs,
  output logic [9:0] RecvX,
  output logic [9:0] RecvY,
  output logic       locked,
  output logic       active,
  output logic       frame_start,
  output logic       hs_err,
  output logic       vs_err,
  output logic [7:0] frame_count
);

  localparam int unsigned CW = 10;

  localparam logic [CW-1:0] X_LAST = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] Y_LAST = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] X_SYNC = CW'(H_SYNC_START);
  localparam logic [CW-1:0] X_RISE = CW'(H_SYNC_START + H_SYNC_WIDTH);
  localparam logic [CW-1:0] Y_SYNC = CW'(V_SYNC_START);
  localparam logic [CW-1:0] X_ACT  = CW'(H_ACTIVE);
  localparam logic [CW-1:0] Y_ACT  = CW'(V_ACTIVE);

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    H_ALIGN = 2'd1,
    V_ALIGN = 2'd2,
    LOCKED  = 2'd3
  } state_t;

  state_t        state_q;
  state_t        state_nxt;
  logic          hs_q;
  logic          vs_q;
  logic          hs_fall;
  logic          hs_rise;
  logic          vs_fall;
  logic          x_wrap;
  logic [CW-1:0] x_inc;
  logic [CW-1:0] y_inc;
  logic [CW-1:0] x_nxt;
  logic [CW-1:0] y_nxt;
  logic          hs_bad;
  logic          vs_bad;
  logic          lock_nxt;
  logic          act_nxt;
  logic          fs_nxt;

  // Per-strobe next values: edge detect, predicted counters, checks, FSM.
  always_comb begin
    hs_fall   = 1'b0;
    hs_rise   = 1'b0;
    vs_fall   = 1'b0;
    x_wrap    = 1'b0;
    x_inc     = '0;
    y_inc     = '0;
    x_nxt     = '0;
    y_nxt     = '0;
    hs_bad    = 1'b0;
    vs_bad    = 1'b0;
    state_nxt = state_q;
    lock_nxt  = 1'b0;
    act_nxt   = 1'b0;
    fs_nxt    = 1'b0;

    // Current input is the new sample, hs_q/vs_q the previous one.
    hs_fall = hs_q & ~hs;
    hs_rise = ~hs_q & hs;
    vs_fall = vs_q & ~vs;

    // Predicted values: what the counters hold after this strobe's increment.
    x_wrap = (RecvX == X_LAST);
    x_inc  = x_wrap ? '0 : RecvX + CW'(1);
    if (x_wrap) begin
      y_inc = (RecvY == Y_LAST) ? '0 : RecvY + CW'(1);
    end else begin
      y_inc = RecvY;
    end

    // A sync fall re-aligns the counter regardless of whether it was on time.
    x_nxt = hs_fall ? X_SYNC : x_inc;
    y_nxt = vs_fall ? Y_SYNC : y_inc;

    // The rise is checked against the predicted column, i.e. the column being
    // sampled, so a nominal pulse rises exactly H_SYNC_WIDTH after its fall.
    if (state_q != SEARCH) begin
      hs_bad = (hs_fall && (x_inc != X_SYNC)) || (hs_rise && (x_inc != X_RISE));
    end
    if ((state_q == V_ALIGN) || (state_q == LOCKED)) begin
      vs_bad = vs_fall && (y_inc != Y_SYNC);
    end

    if (hs_bad || vs_bad) begin
      state_nxt = SEARCH;
    end else begin
      case (state_q)
        SEARCH:  if (hs_fall) state_nxt = H_ALIGN;
        H_ALIGN: if (vs_fall) state_nxt = V_ALIGN;
        V_ALIGN: if (vs_fall) state_nxt = LOCKED;
        LOCKED:  state_nxt = LOCKED;
        default: state_nxt = SEARCH;
      endcase
    end

    // Status outputs follow the updated state and counters of this strobe.
    lock_nxt = (state_nxt == LOCKED);
    act_nxt  = lock_nxt && (x_nxt < X_ACT) && (y_nxt < Y_ACT);
    fs_nxt   = lock_nxt && (x_nxt == '0) && (y_nxt == '0);
  end

  // State, counters and outputs; pulses clear on every Clk, the rest hold.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q     <= SEARCH;
      hs_q        <= 1'b1;
      vs_q        <= 1'b1;
      RecvX       <= '0;
      RecvY       <= '0;
      locked      <= 1'b0;
      active      <= 1'b0;
      frame_start <= 1'b0;
      hs_err      <= 1'b0;
      vs_err      <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      hs_err      <= 1'b0;
      vs_err      <= 1'b0;
      if (pix_ce) begin
        state_q     <= state_nxt;
        hs_q        <= hs;
        vs_q        <= vs;
        RecvX       <= x_nxt;
        RecvY       <= y_nxt;
        locked      <= lock_nxt;
        active      <= act_nxt;
        frame_start <= fs_nxt;
        hs_err      <= hs_bad;
        vs_err      <= vs_bad;
      end
    end
  end

`ifdef VGA_RX_FRAME_COUNT_EN
  // Locked-frame counter; wraps naturally at 8 bits, zero whenever unlocked.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      frame_count <= '0;
    end else if (pix_ce) begin
      if (!lock_nxt) begin
        frame_count <= '0;
      end else if (fs_nxt) begin
        frame_count <= frame_count + 8'(1);
      end
    end
  end
`else
  assign frame_count = '0;
`endif

endmodule

// File: tb/tb_vga_sync_receiver.sv
// tb_vga_sync_receiver: directed bench for vga_sync_receiver.
// Uses a reduced 16x8 timing (sync at column 12 width 2, line 6 two lines)
// so whole frames fit in a short run; pix_ce strobes every second Clk.
// A small transmitter model drives the syncs; expected positions and strobe
// indices of lock/error events are worked out by hand from that timing.

module tb_vga_sync_receiver;

  localparam int H_T   = 16;
  localparam int H_A   = 10;
  localparam int H_SS  = 12;
  localparam int H_SW  = 2;
  localparam int V_T   = 8;
  localparam int V_A   = 5;
  localparam int V_SS  = 6;
  localparam int FRAME = H_T * V_T;

`ifdef VGA_RX_FRAME_COUNT_EN
  localparam int FC_FRAMES = 256;
  localparam int FC_FIRST  = 1;
  localparam int FC_END    = 1;
`else
  localparam int FC_FRAMES = 2;
  localparam int FC_FIRST  = 0;
  localparam int FC_END    = 0;
`endif

  logic       Clk;
  logic       Reset;
  logic       pix_ce;
  logic       hs;
  logic       vs;
  logic [9:0] RecvX;
  logic [9:0] RecvY;
  logic       locked;
  logic       active;
  logic       frame_start;
  logic       hs_err;
  logic       vs_err;
  logic [7:0] frame_count;

  vga_sync_receiver #(
    .H_TOTAL     (H_T),
    .H_ACTIVE    (H_A),
    .H_SYNC_START(H_SS),
    .H_SYNC_WIDTH(H_SW),
    .V_TOTAL     (V_T),
    .V_ACTIVE    (V_A),
    .V_SYNC_START(V_SS)
  ) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .pix_ce     (pix_ce),
    .hs         (hs),
    .vs         (vs),
    .RecvX      (RecvX),
    .RecvY      (RecvY),
    .locked     (locked),
    .active     (active),
    .frame_start(frame_start),
    .hs_err     (hs_err),
    .vs_err     (vs_err),
    .frame_count(frame_count)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_err    = 0;

  // Transmitter model and its sync-shape overrides.
  int sidx = 0;
  int tx_x = 0;
  int tx_y = 0;
  int hs_lo = H_SS;
  int hs_hi = H_SS + H_SW;
  int vs_lo = V_SS;
  bit hs_force = 1'b0;
  bit vs_force = 1'b0;

  // Per-strobe accumulators.
  int n_hs_err = 0;
  int n_vs_err = 0;
  int n_act = 0;
  int n_fs = 0;
  int n_track_bad = 0;
  int n_hold_bad = 0;
  int n_fc_bad = 0;

  // Outputs captured just after the most recent strobe.
  logic [9:0] obs_x;
  logic [9:0] obs_y;
  logic       obs_locked;
  logic       obs_active;
  logic       obs_fs;
  logic       obs_hs_err;
  logic       obs_vs_err;
  logic [7:0] obs_fc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One strobe Clk followed by one idle Clk with inverted (unsampled) syncs.
  task automatic strobe();
    hs     = !(((tx_x >= hs_lo) && (tx_x < hs_hi)) || hs_force);
    vs     = !(((tx_y >= vs_lo) && (tx_y < V_SS + 2)) || vs_force);
    pix_ce = 1'b1;
    @(posedge Clk);
    #1;
    obs_x      = RecvX;
    obs_y      = RecvY;
    obs_locked = locked;
    obs_active = active;
    obs_fs     = frame_start;
    obs_hs_err = hs_err;
    obs_vs_err = vs_err;
    obs_fc     = frame_count;
    if (hs_err) n_hs_err++;
    if (vs_err) n_vs_err++;
    if (active) n_act++;
    if (frame_start) n_fs++;
    if (locked && ((RecvX != 10'(tx_x)) || (RecvY != 10'(tx_y)))) n_track_bad++;
`ifndef VGA_RX_FRAME_COUNT_EN
    if (frame_count != 8'd0) n_fc_bad++;
`endif
    pix_ce = 1'b0;
    hs     = ~hs;
    vs     = ~vs;
    if (tx_x == H_T - 1) begin
      tx_x = 0;
      tx_y = (tx_y == V_T - 1) ? 0 : tx_y + 1;
    end else begin
      tx_x++;
    end
    @(posedge Clk);
    #1;
    if (frame_start || hs_err || vs_err || (RecvX != obs_x) || (RecvY != obs_y) ||
        (locked != obs_locked) || (active != obs_active))
      n_hold_bad++;
    sidx++;
  endtask

  task automatic run_to(input int target);
    while (sidx < target) strobe();
  endtask

  int s_base;

  initial begin
    Reset  = 1'b1;
    pix_ce = 1'b0;
    hs     = 1'b1;
    vs     = 1'b1;
    repeat (2) @(posedge Clk);
    #1;
    chk("rst_x", RecvX, 0);
    chk("rst_y", RecvY, 0);
    chk("rst_locked", locked, 0);
    chk("rst_active", active, 0);
    chk("rst_fs", frame_start, 0);
    chk("rst_hs_err", hs_err, 0);
    chk("rst_vs_err", vs_err, 0);
    chk("rst_fc", frame_count, 0);
    @(negedge Clk);
    Reset = 1'b0;

    // Acquisition: hs fall line 0, vs falls at strobes 96 and 224.
    run_to(96);
    strobe();
    chk("vs1_locked", obs_locked, 0);
    chk("vs1_y_load", obs_y, V_SS);
    chk("vs1_x", obs_x, 0);
    run_to(224);
    chk("prelock", obs_locked, 0);
    strobe();
    chk("lock", obs_locked, 1);
    chk("lock_x", obs_x, 0);
    chk("lock_y", obs_y, V_SS);
    chk("acq_errs", n_hs_err + n_vs_err, 0);

    // One full locked frame.
    run_to(2 * FRAME);
    n_act = 0;
    n_fs  = 0;
    strobe();
    chk("fs_pulse", obs_fs, 1);
    run_to(3 * FRAME);
    chk("fs_per_frame", n_fs, 1);
    chk("active_per_frame", n_act, H_A * V_A);

    // hs fall 4 pixels early on line 2 of frame 3.
    run_to(3 * FRAME + 2 * H_T + 8);
    hs_lo = H_SS - 4;
    strobe();
    chk("early_hs_err", obs_hs_err, 1);
    chk("early_vs_err", obs_vs_err, 0);
    chk("early_locked", obs_locked, 0);
    chk("early_x_load", obs_x, H_SS);
    run_to(3 * FRAME + 3 * H_T);
    hs_lo = H_SS;
    run_to(3 * FRAME + 96);
    strobe();
    chk("early_relock_vs1", obs_locked, 0);
    run_to(4 * FRAME + 96);
    strobe();
    chk("early_relock", obs_locked, 1);
    chk("early_err_count", n_hs_err, 1);

    // hs pulse one pixel short on line 7 of frame 4.
    run_to(4 * FRAME + 7 * H_T + H_SS);
    hs_hi = H_SS + 1;
    strobe();
    chk("short_fall_ok", obs_hs_err, 0);
    strobe();
    chk("short_rise_err", obs_hs_err, 1);
    chk("short_locked", obs_locked, 0);
    hs_hi = H_SS + H_SW;
    run_to(6 * FRAME + 96);
    strobe();
    chk("short_relock", obs_locked, 1);

    // vs falls one line early (line 5) in frame 7.
    run_to(7 * FRAME + 5 * H_T);
    vs_lo = V_SS - 1;
    strobe();
    chk("vs_early_err", obs_vs_err, 1);
    chk("vs_early_hs_err", obs_hs_err, 0);
    chk("vs_early_locked", obs_locked, 0);
    chk("vs_early_y_load", obs_y, V_SS);
    chk("vs_early_x", obs_x, 0);
    run_to(8 * FRAME);
    vs_lo = V_SS;
    run_to(9 * FRAME + 96);
    strobe();
    chk("vs_relock", obs_locked, 1);

    // Reset mid-frame at (5,3) of frame 10.
    run_to(10 * FRAME + 3 * H_T + 5);
    strobe();
    chk("pre_rst_x", obs_x, 5);
    chk("pre_rst_y", obs_y, 3);
    chk("pre_rst_active", obs_active, 1);
    #2;
    Reset = 1'b1;
    #1;
    chk("mid_rst_x", RecvX, 0);
    chk("mid_rst_y", RecvY, 0);
    chk("mid_rst_locked", locked, 0);
    chk("mid_rst_active", active, 0);
    chk("mid_rst_fc", frame_count, 0);
    @(negedge Clk);
    Reset = 1'b0;
    run_to(10 * FRAME + 96);
    strobe();
    chk("rst_relock_vs1", obs_locked, 0);
    run_to(11 * FRAME + 96);
    strobe();
    chk("rst_relock", obs_locked, 1);

    // Frame counter over many locked frames.
    run_to(12 * FRAME);
    strobe();
    chk("fc_fs", obs_fs, 1);
    chk("fc_first", obs_fc, FC_FIRST);
    s_base = 12 * FRAME + FC_FRAMES * FRAME;
    run_to(s_base);
    strobe();
    chk("fc_end", obs_fc, FC_END);

    // Simultaneous misplaced hs and vs falls at (4,2).
    run_to(s_base + 2 * H_T + 4);
    hs_force = 1'b1;
    vs_force = 1'b1;
    strobe();
    chk("both_hs_err", obs_hs_err, 1);
    chk("both_vs_err", obs_vs_err, 1);
    chk("both_x_load", obs_x, H_SS);
    chk("both_y_load", obs_y, V_SS);
    chk("both_locked", obs_locked, 0);
    chk("both_fc_clear", obs_fc, 0);
    hs_force = 1'b0;
    vs_force = 1'b0;
    strobe();
    strobe();

    chk("track_bad", n_track_bad, 0);
    chk("hold_bad", n_hold_bad, 0);
    chk("fc_nonzero", n_fc_bad, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
